// File: rtl/vcc_wr_collector.sv
// vcc_wr_collector: buffers per-lane VCC writes from SIMD/SIMF sources in small FIFOs
// and round-robins them onto exec's registered VCC write port, yielding to SALU writes.
module vcc_wr_collector #(
    parameter int NUM_SRC    = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int WFID_W     = 6,
    parameter int VCC_W      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_vcc_wr_en,
    input  logic [NUM_SRC*WFID_W-1:0] src_vcc_wr_wfid,
    input  logic [NUM_SRC*VCC_W-1:0]  src_vcc_wr_value,
    output logic [NUM_SRC-1:0]        src_vcc_wr_ready,
    input  logic                      salu_wr_vcc_en,
    output logic                      exec_vcc_wr_en,
    output logic [WFID_W-1:0]         exec_vcc_wr_wfid,
    output logic [VCC_W-1:0]          exec_vcc_wr_value,
    output logic [2:0]                exec_vcc_wr_src,
    output logic                      issue_valu_wr_vcc_en,
    output logic [WFID_W-1:0]         issue_valu_wr_vcc_wfid,
    output logic                      overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WFID_W + VCC_W;

    logic [NUM_SRC-1:0] push, pop, not_empty;
    logic [EW-1:0]      head [NUM_SRC];
    logic [2:0]         rr_ptr, gnt, idx;
    logic               gnt_vld;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] rd_ptr, wr_ptr;
        logic [CW-1:0] count;
        // ready looks only at the registered count, so a same-cycle pop never raises it
        assign src_vcc_wr_ready[g] = count < CW'(FIFO_DEPTH);
        assign push[g]      = src_vcc_wr_en[g] & src_vcc_wr_ready[g];
        assign pop[g]       = gnt_vld && gnt == 3'(g);
        assign not_empty[g] = count != '0;
        assign head[g]      = mem[rd_ptr];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g]) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push[g]) - CW'(pop[g]);
            end
        end
        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr] <= {src_vcc_wr_wfid[g*WFID_W +: WFID_W], src_vcc_wr_value[g*VCC_W +: VCC_W]};
        end
    end

    // first non-empty FIFO scanning upward from the pointer wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = 3'((32'(rr_ptr) + k) % NUM_SRC);
            if (!gnt_vld && !salu_wr_vcc_en && not_empty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_vcc_wr_en    <= 1'b0;
            exec_vcc_wr_wfid  <= '0;
            exec_vcc_wr_value <= '0;
            exec_vcc_wr_src   <= '0;
            rr_ptr            <= '0;
            overflow_err      <= 1'b0;
        end else begin
            exec_vcc_wr_en <= gnt_vld;
            if (gnt_vld) begin
                {exec_vcc_wr_wfid, exec_vcc_wr_value} <= head[gnt];
                exec_vcc_wr_src <= gnt;
                rr_ptr          <= 3'((32'(gnt) + 1) % NUM_SRC);
            end
            if (|(src_vcc_wr_en & ~src_vcc_wr_ready)) overflow_err <= 1'b1;
        end
    end

    assign issue_valu_wr_vcc_en   = exec_vcc_wr_en;
    assign issue_valu_wr_vcc_wfid = exec_vcc_wr_wfid;
endmodule

// File: tb/tb_vcc_wr_collector.sv
// tb_vcc_wr_collector: directed checks of reset, single write, round-robin, SALU stall,
// full/overflow and mid-stream reset.
module tb_vcc_wr_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   src_vcc_wr_en;
    logic [47:0]  src_vcc_wr_wfid;
    logic [511:0] src_vcc_wr_value;
    logic [7:0]   src_vcc_wr_ready;
    logic         salu_wr_vcc_en;
    logic         exec_vcc_wr_en;
    logic [5:0]   exec_vcc_wr_wfid;
    logic [63:0]  exec_vcc_wr_value;
    logic [2:0]   exec_vcc_wr_src;
    logic         issue_valu_wr_vcc_en;
    logic [5:0]   issue_valu_wr_vcc_wfid;
    logic         overflow_err;
    int           n_cmp = 0;
    int           n_err = 0;

    vcc_wr_collector dut (
        .clk(clk), .rst(rst),
        .src_vcc_wr_en(src_vcc_wr_en), .src_vcc_wr_wfid(src_vcc_wr_wfid),
        .src_vcc_wr_value(src_vcc_wr_value), .src_vcc_wr_ready(src_vcc_wr_ready),
        .salu_wr_vcc_en(salu_wr_vcc_en),
        .exec_vcc_wr_en(exec_vcc_wr_en), .exec_vcc_wr_wfid(exec_vcc_wr_wfid),
        .exec_vcc_wr_value(exec_vcc_wr_value), .exec_vcc_wr_src(exec_vcc_wr_src),
        .issue_valu_wr_vcc_en(issue_valu_wr_vcc_en), .issue_valu_wr_vcc_wfid(issue_valu_wr_vcc_wfid),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [5:0] w, input logic [63:0] v);
        src_vcc_wr_en[i]           = 1'b1;
        src_vcc_wr_wfid[i*6 +: 6]  = w;
        src_vcc_wr_value[i*64 +: 64] = v;
    endtask

    task automatic commit(input string tag, input logic [2:0] s, input logic [5:0] w, input logic [63:0] v);
        chk({tag, "_en"}, 64'(exec_vcc_wr_en), 64'd1);
        chk({tag, "_src"}, 64'(exec_vcc_wr_src), 64'(s));
        chk({tag, "_wfid"}, 64'(exec_vcc_wr_wfid), 64'(w));
        chk({tag, "_value"}, exec_vcc_wr_value, v);
        chk({tag, "_issue_en"}, 64'(issue_valu_wr_vcc_en), 64'd1);
        chk({tag, "_issue_wfid"}, 64'(issue_valu_wr_vcc_wfid), 64'(w));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        src_vcc_wr_en = '0;
        src_vcc_wr_wfid = '0;
        src_vcc_wr_value = '0;
        salu_wr_vcc_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(src_vcc_wr_ready), 64'hFF);
        chk("rst_en", 64'(exec_vcc_wr_en), 64'd0);
        chk("rst_issue_en", 64'(issue_valu_wr_vcc_en), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        rst = 1'b1;

        @(negedge clk);
        set_src(1, 6'd2, 64'h5);
        @(negedge clk);
        src_vcc_wr_en = '0;
        chk("single_bubble", 64'(exec_vcc_wr_en), 64'd0);
        @(negedge clk);
        commit("single", 3'd1, 6'd2, 64'h5);
        @(negedge clk);
        chk("single_drop", 64'(exec_vcc_wr_en), 64'd0);
        chk("single_hold", exec_vcc_wr_value, 64'h5);

        do_reset();
        for (int i = 0; i < 8; i++) set_src(i, 6'(i), 64'(i));
        @(negedge clk);
        src_vcc_wr_en = '0;
        chk("rr_bubble", 64'(exec_vcc_wr_en), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            commit($sformatf("rr%0d", k), 3'(k), 6'(k), 64'(k));
        end
        @(negedge clk);
        chk("rr_idle", 64'(exec_vcc_wr_en), 64'd0);

        salu_wr_vcc_en = 1'b1;
        set_src(6, 6'd9, 64'hABCD);
        @(negedge clk);
        src_vcc_wr_en = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("salu_stall%0d", k), 64'(exec_vcc_wr_en), 64'd0);
        end
        salu_wr_vcc_en = 1'b0;
        @(negedge clk);
        commit("salu_rel", 3'd6, 6'd9, 64'hABCD);
        @(negedge clk);
        chk("salu_idle", 64'(exec_vcc_wr_en), 64'd0);

        salu_wr_vcc_en = 1'b1;
        set_src(0, 6'd3, 64'hA);
        @(negedge clk);
        set_src(0, 6'd4, 64'hB);
        @(negedge clk);
        chk("full_ready0", 64'(src_vcc_wr_ready[0]), 64'd0);
        chk("full_ovf_pre", 64'(overflow_err), 64'd0);
        set_src(0, 6'd5, 64'hC);
        @(negedge clk);
        src_vcc_wr_en = '0;
        chk("full_ovf", 64'(overflow_err), 64'd1);
        chk("full_ready_still0", 64'(src_vcc_wr_ready[0]), 64'd0);
        salu_wr_vcc_en = 1'b0;
        @(negedge clk);
        commit("full_A", 3'd0, 6'd3, 64'hA);
        chk("full_ready_back", 64'(src_vcc_wr_ready[0]), 64'd1);
        @(negedge clk);
        commit("full_B", 3'd0, 6'd4, 64'hB);
        @(negedge clk);
        chk("full_idle", 64'(exec_vcc_wr_en), 64'd0);
        chk("full_ovf_sticky", 64'(overflow_err), 64'd1);

        salu_wr_vcc_en = 1'b1;
        for (int i = 1; i <= 5; i++) set_src(i, 6'(20 + i), 64'(100 + i));
        @(negedge clk);
        src_vcc_wr_en = '0;
        chk("mid_queued_ready", 64'(src_vcc_wr_ready), 64'hFF);
        rst = 1'b0;
        #1;
        chk("mid_async_ovf", 64'(overflow_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        salu_wr_vcc_en = 1'b0;
        chk("mid_ready", 64'(src_vcc_wr_ready), 64'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_nostrobe%0d", k), 64'(exec_vcc_wr_en), 64'd0);
        end
        set_src(7, 6'd17, 64'h77);
        set_src(0, 6'd10, 64'h70);
        @(negedge clk);
        src_vcc_wr_en = '0;
        @(negedge clk);
        commit("mid_ptr0", 3'd0, 6'd10, 64'h70);
        @(negedge clk);
        commit("mid_ptr7", 3'd7, 6'd17, 64'h77);
        @(negedge clk);
        chk("mid_idle", 64'(exec_vcc_wr_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
